uart_tx_stream: RTL and testbench
=================================

Name: uart_tx_stream

Overview:
- Consumer end of the flushable valid/ready byte stream. Drains words from the stream buffer stage and serializes them onto the UART TX line.
- Each accepted word becomes one asynchronous serial frame: start, data LSB-first, optional parity, 1 or 2 stop bits.
- Sits between the AXI-side TX data path and the pad. Shares flush semantics with the stream stages upstream.

Parameters:
- DataBits, 8, data bits per frame; legal 5..8; data_i width.
- ClkDivWidth, 16, width of the clocks-per-bit configuration.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- flush_i  input  1  synchronous abort of the current frame; blocks acceptance.
- valid_i  input  1  stream data valid.
- ready_o  output  1  stream ready; a handshake occurs when valid_i && ready_o.
- data_i  input  DataBits  stream payload.
- cfg_clk_div_i  input  ClkDivWidth  clock cycles per serial bit; 0 is treated as 1.
- cfg_parity_en_i  input  1  parity bit inserted after the data bits.
- cfg_parity_odd_i  input  1  1 = odd parity, 0 = even parity.
- cfg_stop2_i  input  1  1 = two stop bits, 0 = one stop bit.
- tx_o  output  1  serial line; idle high; registered output.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_i high, asynchronous):
  - state = IDLE; tx_o = 1; busy_o = 0.
  - ready_o = 1 unless flush_i is high.
  - Shift register, bit counter and divider counter cleared.
- ready_o = (state == IDLE) && !flush_i. It is combinational from state and flush_i only; it never depends on valid_i.
- Handshake in IDLE:
  - data_i is latched.
  - cfg_clk_div_i, cfg_parity_en_i, cfg_parity_odd_i and cfg_stop2_i are captured into shadow registers.
  - Configuration changes mid-frame have no effect on the current frame.
- Bit period N = max(cfg_clk_div_i, 1) cycles. Every serial bit holds tx_o for exactly N cycles.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx_o = 1. Handshake -> START.
  - START: tx_o = 0 for N cycles -> DATA.
  - DATA: tx_o = shift[0]; shift right every N cycles; DataBits bits. Then -> PARITY if parity is enabled, otherwise -> STOP.
  - PARITY: tx_o = ^data XOR odd, for N cycles -> STOP.
  - STOP: tx_o = 1 for N cycles (2N if stop2) -> IDLE.
- Latency: tx_o falls in the first cycle after the handshake edge.
- Frame length F = N*(1 + DataBits + P + S) cycles, where P = parity_en and S = 1 or 2.
- Back-to-back traffic: IDLE lasts at least one cycle between frames, giving exactly 1 idle-high cycle between frames. Handshake-to-handshake spacing is therefore F+1 cycles.
- valid_i may be held high across a frame; no data is accepted until IDLE.
- flush_i high in any state:
  - Next state is IDLE; tx_o = 1 from the next cycle.
  - Counters are cleared; the partial frame is discarded.
  - No handshake occurs in any cycle with flush_i high.
- flush_i and valid_i high together in IDLE: no handshake; the word is not consumed.
- Reset mid-frame: tx_o returns high immediately (asynchronously); FSM to IDLE.
- Divider counter width is ClkDivWidth and counts 0..N-1. At cfg_clk_div_i = 0 or 1 the block produces one bit per cycle.

Test Plan:
- DataBits=8, N=4, 8N1, send 0x55 → tx_o: 0 for 4 cycles, then data bits 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles. busy_o high for 40 cycles. Next ready_o at cycle 41.
- N=2, parity enabled, send 0x03 even then 0x03 odd → parity bit 0 for the first frame, 1 for the second. Each frame 22 cycles; handshake spacing 23 cycles.
- valid_i held high with words 0xA1, 0xB2; N=1, 8N2 → two frames of 11 cycles each. Exactly one idle-high cycle between them; both words accepted in order.
- N=3, flush_i pulsed during data bit 3 of 0xFF → tx_o = 1 next cycle; busy_o = 0. ready_o low during the flush cycle, high after. Next word is sent as a complete, correct frame.
- rst_i asserted mid-stop-bit, and cfg_clk_div_i changed to 8 mid-frame → on reset, tx_o = 1 and busy_o = 0 without a clock edge. The mid-frame divider change does not alter the current frame's bit width; it applies from the next handshake.
- cfg_clk_div_i = 0, send 0x80 → 1-cycle bits: 0,0,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: drains a flushable valid/ready word stream onto a UART TX line.
// One frame per accepted word: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_stream #(
    parameter int DataBits    = 8,
    parameter int ClkDivWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [DataBits-1:0]    data_i,
    input  logic [ClkDivWidth-1:0] cfg_clk_div_i,
    input  logic                   cfg_parity_en_i,
    input  logic                   cfg_parity_odd_i,
    input  logic                   cfg_stop2_i,
    output logic                   tx_o,
    output logic                   busy_o
);
    localparam int CntW = $clog2(DataBits);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                 state_q, state_d;
    logic [DataBits-1:0]    shift_q, shift_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ClkDivWidth-1:0] div_cnt_q, div_cnt_d;
    logic [ClkDivWidth-1:0] div_last_q, div_last_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop2_q, stop2_d;
    logic                   tx_q, tx_d;
    logic                   bit_done;
    logic                   hs;

    assign ready_o  = (state_q == IDLE) && !flush_i;
    assign hs       = valid_i && ready_o;
    assign busy_o   = state_q != IDLE;
    assign tx_o     = tx_q;
    assign bit_done = div_cnt_q == div_last_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = bit_done ? '0 : div_cnt_q + ClkDivWidth'(1);
        div_last_d = div_last_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                if (hs) begin
                    state_d    = START;
                    shift_d    = data_i;
                    div_last_d = (cfg_clk_div_i == '0) ? '0 : cfg_clk_div_i - ClkDivWidth'(1);
                    par_en_d   = cfg_parity_en_i;
                    par_bit_d  = ^data_i ^ cfg_parity_odd_i;
                    stop2_d    = cfg_stop2_i;
                end
            end
            START: if (bit_done) state_d = DATA;
            DATA: if (bit_done) begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == CntW'(DataBits - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP: if (bit_done) begin
                // bit_cnt marks the first of two stop bits already sent
                bit_cnt_d = CntW'(1);
                if (!stop2_q || bit_cnt_q != '0) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end
        tx_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? shift_d[0] :
               (state_d == PARITY) ? par_bit_q : 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            div_last_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            div_last_q <= div_last_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed and random frames checked cycle by cycle against
// an expected bit list built from the frame format.
module tb_uart_tx_stream;
    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_o;
    logic [7:0]  data_i;
    logic [15:0] cfg_clk_div_i;
    logic        cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i;
    logic        tx_o, busy_o;
    int          checks = 0;
    int          errors = 0;

    uart_tx_stream #(.DataBits(8), .ClkDivWidth(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_i(data_i), .cfg_clk_div_i(cfg_clk_div_i),
        .cfg_parity_en_i(cfg_parity_en_i), .cfg_parity_odd_i(cfg_parity_odd_i),
        .cfg_stop2_i(cfg_stop2_i), .tx_o(tx_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // kind: 0 = full frame, 1 = flush at cycle abort_at, 2 = reset at cycle abort_at
    task automatic send(input logic [7:0] d, input logic [15:0] div, input logic pe,
                        input logic po, input logic s2, input int abort_at,
                        input int kind, input bit b2b);
        logic bits[$];
        int   n, f, w;
        n = (div == 0) ? 1 : int'(div);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(^d ^ po);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        f = n * bits.size();
        w = 0;
        while (!ready_o && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("ready_before_frame", ready_o, 1'b1);
        if (b2b) chk("back_to_back_spacing", w == 0, 1'b1);
        data_i = d; cfg_clk_div_i = div; cfg_parity_en_i = pe;
        cfg_parity_odd_i = po; cfg_stop2_i = s2; valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'($urandom_range(0, 1));
        data_i  = 8'($urandom);
        for (int k = 0; k < f; k++) begin
            chk("tx_bit", tx_o, bits[k / n]);
            chk("busy_in_frame", busy_o, 1'b1);
            chk("ready_in_frame", ready_o, 1'b0);
            if (k == f / 2) begin
                cfg_clk_div_i    = (kind == 2) ? 16'd8 : 16'($urandom_range(0, 6));
                cfg_parity_en_i  = 1'($urandom);
                cfg_parity_odd_i = 1'($urandom);
                cfg_stop2_i      = 1'($urandom);
            end
            if (k == abort_at) begin
                valid_i = 1'b0;
                if (kind == 1) begin
                    flush_i = 1'b1;
                    #1 chk("ready_during_flush", ready_o, 1'b0);
                    @(negedge clk_i);
                    chk("tx_after_flush", tx_o, 1'b1);
                    chk("busy_after_flush", busy_o, 1'b0);
                    flush_i = 1'b0;
                    #1 chk("ready_after_flush", ready_o, 1'b1);
                end else begin
                    rst_i = 1'b1;
                    #1 chk("tx_async_reset", tx_o, 1'b1);
                    chk("busy_async_reset", busy_o, 1'b0);
                    chk("ready_async_reset", ready_o, 1'b1);
                    @(negedge clk_i);
                    rst_i = 1'b0;
                end
                return;
            end
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        chk("tx_idle_gap", tx_o, 1'b1);
        chk("busy_idle_gap", busy_o, 1'b0);
        chk("ready_idle_gap", ready_o, 1'b1);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
        cfg_clk_div_i = '0; cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0; cfg_stop2_i = 1'b0;
        #1;
        chk("reset_tx", tx_o, 1'b1);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_ready", ready_o, 1'b1);
        flush_i = 1'b1;
        #1 chk("reset_ready_flush", ready_o, 1'b0);
        flush_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        send(8'h55, 16'd4, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
        send(8'h03, 16'd2, 1'b1, 1'b0, 1'b0, -1, 0, 1'b1);
        send(8'h03, 16'd2, 1'b1, 1'b1, 1'b0, -1, 0, 1'b1);
        send(8'hA1, 16'd1, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        send(8'hB2, 16'd1, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
        send(8'hFF, 16'd3, 1'b0, 1'b0, 1'b0, 13, 1, 1'b0);
        send(8'h3C, 16'd3, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
        flush_i = 1'b1; valid_i = 1'b1; data_i = 8'h77;
        #1 chk("ready_flush_valid_idle", ready_o, 1'b0);
        @(negedge clk_i);
        chk("busy_flush_valid_idle", busy_o, 1'b0);
        chk("tx_flush_valid_idle", tx_o, 1'b1);
        flush_i = 1'b0; valid_i = 1'b0;
        send(8'h5A, 16'd2, 1'b0, 1'b0, 1'b0, 19, 2, 1'b0);
        send(8'h96, 16'd8, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
        send(8'h80, 16'd0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b1);
        for (int r = 0; r < 24; r++) begin
            logic [15:0] dv;
            int          ab;
            dv = 16'($urandom_range(0, 4));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            send(8'($urandom), dv, 1'($urandom), 1'($urandom), 1'($urandom), ab,
                 (ab < 0) ? 0 : 1, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
